// File: rtl/iob_dma_sched.sv
// Round-robin scheduler for the iob_dma axis2axi datapath: grants one descriptor at a time,
// runs the config handshake, counts stream beats and returns per-channel ack/done pulses.
module iob_dma_sched #(
    parameter int N_CH       = 4,
    parameter int AXI_ADDR_W = 24,
    parameter int LEN_W      = 16,
    parameter int SEL_W      = 2
) (
    input  logic                       clk_i,
    input  logic                       arst_n_i,
    input  logic                       cke_i,
    input  logic [N_CH-1:0]            req_i,
    input  logic [N_CH-1:0]            dir_i,
    input  logic [N_CH*AXI_ADDR_W-1:0] addr_i,
    input  logic [N_CH*LEN_W-1:0]      len_i,
    output logic [N_CH-1:0]            ack_o,
    output logic [N_CH-1:0]            done_o,
    output logic                       err_o,
    output logic                       busy_o,
    output logic [SEL_W-1:0]           sel_o,
    output logic [AXI_ADDR_W-1:0]      cfg_addr_o,
    output logic [LEN_W-1:0]           cfg_len_o,
    output logic                       cfg_in_valid_o,
    input  logic                       cfg_in_ready_i,
    output logic                       cfg_out_valid_o,
    input  logic                       cfg_out_ready_i,
    input  logic                       beat_i,
    input  logic                       abort_i
);
    typedef enum logic [1:0] {S_IDLE, S_CFG, S_XFER, S_DONE} state_t;

    state_t                  state_q, state_d;
    logic [SEL_W-1:0]        last_q, last_d;
    logic [SEL_W-1:0]        sel_q, sel_d;
    logic                    dir_q, dir_d;
    logic                    err_q, err_d;
    logic [AXI_ADDR_W-1:0]   addr_q, addr_d;
    logic [LEN_W-1:0]        len_q, len_d;
    logic [LEN_W-1:0]        cnt_q, cnt_d;
    logic [N_CH-1:0]         ack_q, ack_d;

    logic [SEL_W-1:0]        grant;
    logic [SEL_W-1:0]        scan_idx;
    logic                    found;
    logic [LEN_W-1:0]        grant_len;
    logic                    cfg_hs;
    logic                    done_act;

    // Scan upward from the channel after the last completed one, wrapping.
    always_comb begin
        found    = 1'b0;
        grant    = last_q;
        scan_idx = '0;
        for (int i = 1; i <= N_CH; i++) begin
            scan_idx = SEL_W'((int'(last_q) + i) % N_CH);
            if (!found && req_i[scan_idx]) begin
                found = 1'b1;
                grant = scan_idx;
            end
        end
    end

    assign grant_len = len_i[grant*LEN_W +: LEN_W];
    assign cfg_hs    = dir_q ? cfg_in_ready_i : cfg_out_ready_i;

    always_comb begin
        state_d = state_q;
        last_d  = last_q;
        sel_d   = sel_q;
        dir_d   = dir_q;
        err_d   = err_q;
        addr_d  = addr_q;
        len_d   = len_q;
        cnt_d   = cnt_q;
        ack_d   = '0;
        case (state_q)
            S_IDLE: begin
                if (found) begin
                    sel_d        = grant;
                    dir_d        = dir_i[grant];
                    addr_d       = addr_i[grant*AXI_ADDR_W +: AXI_ADDR_W];
                    len_d        = grant_len;
                    err_d        = 1'b0;
                    ack_d[grant] = 1'b1;
                    state_d      = (grant_len == '0) ? S_DONE : S_CFG;
                end
            end
            S_CFG: begin
                if (cfg_hs) begin
                    cnt_d   = '0;
                    state_d = S_XFER;
                end
            end
            S_XFER: begin
                // A final beat outranks a simultaneous abort.
                if (beat_i && (cnt_q == len_q - LEN_W'(1))) begin
                    err_d   = 1'b0;
                    state_d = S_DONE;
                end else if (abort_i) begin
                    err_d   = 1'b1;
                    state_d = S_DONE;
                end else if (beat_i) begin
                    cnt_d = cnt_q + LEN_W'(1);
                end
            end
            S_DONE: begin
                // A zero-length grant lands here with its ack still showing; done waits one cycle.
                if (ack_q == '0) begin
                    last_d  = sel_q;
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge arst_n_i) begin
        if (!arst_n_i) begin
            state_q <= S_IDLE;
            last_q  <= SEL_W'(N_CH - 1);
            sel_q   <= '0;
            dir_q   <= 1'b0;
            err_q   <= 1'b0;
            addr_q  <= '0;
            len_q   <= '0;
            cnt_q   <= '0;
            ack_q   <= '0;
        end else if (cke_i) begin
            state_q <= state_d;
            last_q  <= last_d;
            sel_q   <= sel_d;
            dir_q   <= dir_d;
            err_q   <= err_d;
            addr_q  <= addr_d;
            len_q   <= len_d;
            cnt_q   <= cnt_d;
            ack_q   <= ack_d;
        end
    end

    assign done_act = (state_q == S_DONE) && (ack_q == '0);

    always_comb begin
        done_o = '0;
        if (done_act) begin
            done_o[sel_q] = 1'b1;
        end
    end

    assign err_o           = done_act & err_q;
    assign busy_o          = (state_q != S_IDLE);
    assign ack_o           = ack_q;
    assign sel_o           = sel_q;
    assign cfg_addr_o      = addr_q;
    assign cfg_len_o       = len_q;
    assign cfg_in_valid_o  = (state_q == S_CFG) && dir_q;
    assign cfg_out_valid_o = (state_q == S_CFG) && !dir_q;

endmodule
